ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer in front of the single-port data RAM. It lets the CPU data path (port 0) and a secondary master such as a loader or DMA (port 1) share the RAM. It grants at most one access per cycle, using round-robin arbitration with a bounded burst length. It also range-checks every address and returns a registered one-cycle-later response (read data plus error flag) to the granted requester.

## Interface
Parameters:
- RAM_SIZE, 256, RAM depth in 32-bit words; legal word index is addr[31:2] < RAM_SIZE.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting; legal range is 1 to 15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request, held with its qualifiers until granted.
- wr0 / wr1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  32  byte address; word-aligned, bits [1:0] ignored.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  combinational; the transfer occurs in the cycle where reqN & gntN.
- resp0 / resp1  out  1  one-cycle pulse the cycle after a transfer (reads and writes).
- rdata0 / rdata1  out  32  registered read data, valid while respN = 1.
- err0 / err1  out  1  registered, valid with respN; 1 = address out of range.
- MemRd  out  1  to RAM; high for a granted in-range read.
- MemWr  out  1  to RAM; high for a granted in-range write.
- Addr  out  32  to RAM; the granted port's address, 0 when idle.
- WrData  out  32  to RAM; the granted port's wdata, 0 when idle.
- RdData  in  32  combinational read data from RAM.

## Operation
- State: owner ∈ {NONE, P0, P1}, last (the port most recently granted), burst count cnt (4 bits).
- Grant selection, evaluated combinationally each cycle:
  - Neither req: no grant.
  - Exactly one req: grant that port.
  - Both req, owner = NONE: grant the port ≠ last.
  - Both req, owner = Pk, cnt < MAX_BURST: grant Pk.
  - Both req, owner = Pk, cnt = MAX_BURST: grant the other port.
- State update on a transfer to port k:
  - If k = owner, then cnt ← cnt + 1 (saturating at MAX_BURST).
  - Otherwise owner ← Pk and cnt ← 1.
  - In both cases last ← k.
- On a cycle with no transfer: owner ← NONE, cnt ← 0, last unchanged.
- Range check: in range ⇔ addr[31:2] < RAM_SIZE.
  - Out-of-range transfers are still granted.
  - MemRd and MemWr stay 0 for them, so the RAM is untouched.
  - The response carries err = 1 and rdata = 0.
- RAM drive: Addr and WrData mux from the granted port. MemRd = grant & !wr & inrange; MemWr = grant & wr & inrange.
- Response register for the transferred port:
  - respN ← 1 and errN ← !inrange.
  - rdataN ← RdData for an in-range read; otherwise rdataN ← 0.
  - The non-transferred port gets respN ← 0, and its rdataN and errN hold their values.

## Timing
- Reset values: owner = NONE, cnt = 0, last = P1 (so port 0 wins the first tie); resp0/1 = 0, err0/1 = 0, rdata0/1 = 0.
- gnt0/1, MemRd, MemWr, Addr and WrData are combinational. They are therefore 0 during reset if no req is asserted.
- Latency: transfer in cycle T. A RAM write commits at the T→T+1 edge. respN, rdataN and errN are visible during T+1 for one cycle.
- Throughput: one transfer per cycle. Back-to-back transfers from the same port give resp high continuously.
- A requester may change addr, wr and wdata only after the cycle in which it was granted. Deasserting req before grant is legal; no transfer occurs.
- Simultaneous events:
  - A write by port 0 and a read of the same word by port 1 cannot occur in the same cycle.
  - A read in T+1 of a word written in T returns the new data.
- Reset mid-operation: a pending response is discarded (resp forced to 0 immediately). No RAM write is issued while reset is high, even if req is high.
- With MAX_BURST = 1, arbitration is strict alternation whenever both ports request.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF at addr 0x10 and reads it back. Expect: gnt0 = 1 in each transfer cycle; resp0 = 1, err0 = 0 and rdata0 = 0xDEADBEEF one cycle after the read.
- req0 and req1 high from the first cycle after reset. Expect: port 0 is granted first, for 4 consecutive cycles, then port 1 for 4, alternating 4/4 thereafter.
- Port 1 alone requests 10 consecutive cycles. Expect: gnt1 every cycle, with no burst-limit break.
- Port 0 reads addr 0x400 (word 256) and port 1 writes addr 0xFFFFFFFC. Expect:
  - MemRd and MemWr stay 0.
  - The responses carry err = 1 and rdata = 0.
  - RAM word 255 is unchanged.
- Port 0 write to 0x20 in T, then port 1 read of 0x20 in T+1. Expect rdata1 to equal the new data at T+2.
- Assert reset in the cycle after a granted read. Expect: resp0 drops to 0 immediately; owner resets, so the next tie goes to port 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Grants one access per cycle, bounds bursts under contention, and range-checks addresses.
module ram_arbiter #(
    parameter int unsigned RAM_SIZE  = 256,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        resp0,
    output logic        resp1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        MemRd,
    output logic        MemWr,
    output logic [31:0] Addr,
    output logic [31:0] WrData,
    input  logic [31:0] RdData
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t          owner;
    logic            last;
    logic [CW-1:0]   cnt;

    logic            pick1;
    logic            xfer;
    logic            sel_wr;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [31:0]     word_idx;
    logic            inrange;
    logic            rd_ok;

    // Port selection: pick1 chooses port 1 when it is the arbitration winner.
    always_comb begin
        pick1 = 1'b0;
        if (req1 && !req0) begin
            pick1 = 1'b1;
        end else if (req0 && req1) begin
            case (owner)
                OWN_NONE: pick1 = ~last;
                OWN_P0:   pick1 = (cnt >= MAX_CNT);
                OWN_P1:   pick1 = (cnt < MAX_CNT);
                default:  pick1 = 1'b0;
            endcase
        end
    end

    assign gnt0 = req0 & ~pick1;
    assign gnt1 = req1 & pick1;
    assign xfer = gnt0 | gnt1;

    // RAM-side mux; strobes are suppressed while reset is held.
    always_comb begin
        sel_wr    = pick1 ? wr1    : wr0;
        sel_addr  = pick1 ? addr1  : addr0;
        sel_wdata = pick1 ? wdata1 : wdata0;
        word_idx  = {2'b00, sel_addr[31:2]};
        inrange   = (word_idx < 32'(RAM_SIZE));
        rd_ok     = ~sel_wr & inrange;
        Addr      = xfer ? sel_addr  : 32'd0;
        WrData    = xfer ? sel_wdata : 32'd0;
        MemRd     = xfer & ~reset & ~sel_wr & inrange;
        MemWr     = xfer & ~reset & sel_wr & inrange;
    end

    // Ownership / burst tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= OWN_NONE;
            cnt   <= '0;
            last  <= 1'b1;
        end else if (xfer) begin
            if ((pick1 && owner == OWN_P1) || (!pick1 && owner == OWN_P0)) begin
                if (cnt < MAX_CNT) begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                owner <= pick1 ? OWN_P1 : OWN_P0;
                cnt   <= CW'(1);
            end
            last <= pick1;
        end else begin
            owner <= OWN_NONE;
            cnt   <= '0;
        end
    end

    // Registered responses; the idle port keeps its last data/err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp0  <= 1'b0;
            resp1  <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            resp0 <= gnt0;
            resp1 <= gnt1;
            if (gnt0) begin
                err0   <= ~inrange;
                rdata0 <= rd_ok ? RdData : 32'd0;
            end
            if (gnt1) begin
                err1   <= ~inrange;
                rdata1 <= rd_ok ? RdData : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 256-word RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, wr0, req1, wr1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, resp0, resp1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        MemRd, MemWr;
    logic [31:0] Addr, WrData, RdData;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.RAM_SIZE(256), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .resp0(resp0), .resp1(resp1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr), .WrData(WrData),
        .RdData(RdData)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded while reset is high, written on MemWr.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (MemWr) begin
            mem[Addr[9:2]] <= WrData;
        end
    end
    assign RdData = mem[Addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        cyc();
        cyc();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        cyc();
        @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_resp0", 32'(resp0), 32'd0);
        chk("rst_addr", Addr, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        // Request held during reset must not reach the RAM.
        req0 = 1; wr0 = 1; addr0 = 32'h10; wdata0 = 32'h1111_1111;
        @(negedge clk);
        chk("rst_memwr", 32'(MemWr), 32'd0);
        cyc();
        idle_inputs();
        reset = 0;

        // Port 0 write then read-back.
        req0 = 1; wr0 = 1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_gnt0_w", 32'(gnt0), 32'd1);
        chk("t1_memwr", 32'(MemWr), 32'd1);
        chk("t1_wrdata", WrData, 32'hDEAD_BEEF);
        cyc();
        chk("t1_resp0_w", 32'(resp0), 32'd1);
        chk("t1_err0_w", 32'(err0), 32'd0);
        wr0 = 0;
        @(negedge clk);
        chk("t1_gnt0_r", 32'(gnt0), 32'd1);
        chk("t1_memrd", 32'(MemRd), 32'd1);
        chk("t1_addr", Addr, 32'h10);
        cyc();
        idle_inputs();
        chk("t1_resp0_r", 32'(resp0), 32'd1);
        chk("t1_err0_r", 32'(err0), 32'd0);
        chk("t1_rdata0", rdata0, 32'hDEAD_BEEF);
        cyc();
        chk("t1_resp0_idle", 32'(resp0), 32'd0);

        // Contention: 4/4 alternation starting with port 0.
        do_reset();
        req0 = 1; addr0 = 32'h0; req1 = 1; addr1 = 32'h4;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt0_%0d", i), 32'(gnt0), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_gnt1_%0d", i), 32'(gnt1), ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
            cyc();
        end
        idle_inputs();
        cyc();

        // Port 1 alone: no burst break.
        req1 = 1; addr1 = 32'h8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("t3_gnt1_%0d", i), 32'(gnt1), 32'd1);
            cyc();
            chk($sformatf("t3_resp1_%0d", i), 32'(resp1), 32'd1);
        end
        chk("t3_rdata1", rdata1, 32'hA000_0002);
        idle_inputs();
        cyc();

        // Out-of-range accesses.
        req0 = 1; wr0 = 0; addr0 = 32'h400;
        @(negedge clk);
        chk("t4_gnt0", 32'(gnt0), 32'd1);
        chk("t4_memrd", 32'(MemRd), 32'd0);
        chk("t4_memwr0", 32'(MemWr), 32'd0);
        cyc();
        idle_inputs();
        chk("t4_resp0", 32'(resp0), 32'd1);
        chk("t4_err0", 32'(err0), 32'd1);
        chk("t4_rdata0", rdata0, 32'd0);
        req1 = 1; wr1 = 1; addr1 = 32'hFFFF_FFFC; wdata1 = 32'hCAFE_F00D;
        @(negedge clk);
        chk("t4_gnt1", 32'(gnt1), 32'd1);
        chk("t4_memwr1", 32'(MemWr), 32'd0);
        cyc();
        idle_inputs();
        chk("t4_resp1", 32'(resp1), 32'd1);
        chk("t4_err1", 32'(err1), 32'd1);
        chk("t4_rdata1", rdata1, 32'd0);
        chk("t4_word255", mem[255], 32'hA000_00FF);
        chk("t4_err0_hold", 32'(err0), 32'd1);

        // Write by port 0 then immediate read by port 1.
        req0 = 1; wr0 = 1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
        cyc();
        idle_inputs();
        req1 = 1; wr1 = 0; addr1 = 32'h20;
        @(negedge clk);
        chk("t5_gnt1", 32'(gnt1), 32'd1);
        chk("t5_memrd", 32'(MemRd), 32'd1);
        cyc();
        idle_inputs();
        chk("t5_resp1", 32'(resp1), 32'd1);
        chk("t5_err1", 32'(err1), 32'd0);
        chk("t5_rdata1", rdata1, 32'h1234_5678);
        cyc();

        // Reset right after a granted read; next tie must go to port 0.
        req0 = 1; wr0 = 0; addr0 = 32'h10;
        cyc();
        idle_inputs();
        reset = 1;
        #1;
        chk("t6_resp0_rst", 32'(resp0), 32'd0);
        chk("t6_rdata0_rst", rdata0, 32'd0);
        cyc();
        reset = 0;
        req0 = 1; addr0 = 32'h0; req1 = 1; addr1 = 32'h4;
        @(negedge clk);
        chk("t6_tie_gnt0", 32'(gnt0), 32'd1);
        chk("t6_tie_gnt1", 32'(gnt1), 32'd0);
        cyc();
        idle_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
